// File: rtl/spi_packet_slave.sv
// MCU-facing SPI mode-0 slave: 12-byte command packets framed on a magic byte, 96-bit response on MISO.
// All SPI pins are oversampled in the clk domain. Define SPI_PACKET_SLAVE_TIMEOUT_EN to enable mid-packet idle timeout.
module spi_packet_slave #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [7:0] MAGIC          = 8'h5A,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        spi_sck,
  input  logic        spi_n_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        pkt_valid,
  output logic [95:0] pkt_raw,
  output logic [7:0]  pkt_type,
  output logic        pkt_rw,
  output logic [15:0] pkt_index,
  output logic [7:0]  pkt_module,
  output logic [7:0]  pkt_reg,
  output logic [31:0] pkt_value,
  input  logic [95:0] tx_data,
  input  logic        tx_load,
  output logic        tx_busy,
  output logic [15:0] sync_err_cnt,
  output logic [15:0] timeout_cnt
);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Byte k of a packet, byte 0 being the most significant.
  function automatic logic [7:0] pick_byte(input logic [95:0] v, input logic [3:0] k);
    logic [95:0] s;
    s = v << {k, 3'b000};
    return s[95:88];
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_shift_q, rx_shift_d;
  logic [1:0]             state_q, state_d;
  logic [3:0]             byte_cnt_q, byte_cnt_d;
  logic [95:0]            rx_buf_q, rx_buf_d;
  logic [95:0]            pkt_raw_q, pkt_raw_d;
  logic                   pkt_valid_q, pkt_valid_d;
  logic [15:0]            sync_err_q, sync_err_d;
  logic [95:0]            tx_buf_q, tx_buf_d;
  logic                   tx_busy_q, tx_busy_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   fresh_q, fresh_d;
  logic                   miso_q, miso_d;

  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_fall, cs_low;
  logic       bit_done, byte_done, tx_accept, to_hit;
  logic [7:0] rx_byte;
  logic [3:0] tx_idx;
  logic [6:0] rx_sh;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_low    = ~cs_s;
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign bit_done  = sck_rise & cs_low;
  assign byte_done = bit_done & (bit_cnt_q == 3'd7);
  assign rx_byte   = {rx_shift_q, mosi_s};
  assign rx_sh     = 7'd88 - {byte_cnt_q, 3'b000};
  // A load completing in the DONE cycle is accepted because tx_busy clears in that same cycle.
  assign tx_accept = tx_load & (((state_q == ST_HUNT) & ~tx_busy_q) | (state_q == ST_DONE));

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_n_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    rx_buf_d    = rx_buf_q;
    pkt_valid_d = 1'b0;
    pkt_raw_d   = pkt_raw_q;
    sync_err_d  = sync_err_q;
    tx_buf_d    = tx_buf_q;
    tx_busy_d   = tx_busy_q;
    tx_byte_d   = tx_byte_q;
    fresh_d     = fresh_q;
    tx_idx      = byte_cnt_q;

    // Bit receiver: n_cs high drops a partial byte but leaves the byte counter alone.
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      rx_shift_d = rx_byte[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_done) begin
          if (rx_byte == MAGIC) begin
            rx_buf_d[95:88] = rx_byte;
            byte_cnt_d      = 4'd1;
            state_d         = ST_RECV;
          end else begin
            sync_err_d = sat_inc(sync_err_q);
          end
        end
      end
      ST_RECV: begin
        if (to_hit) begin
          state_d    = ST_HUNT;
          byte_cnt_d = 4'd0;
        end else if (byte_done) begin
          rx_buf_d = (rx_buf_q & ~({88'h0, 8'hFF} << rx_sh)) | ({88'h0, rx_byte} << rx_sh);
          if (byte_cnt_q == 4'd11) begin
            state_d    = ST_DONE;
            byte_cnt_d = 4'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        pkt_valid_d = 1'b1;
        pkt_raw_d   = rx_buf_q;
        tx_busy_d   = 1'b0;
        state_d     = ST_HUNT;
        byte_cnt_d  = 4'd0;
      end
      default: begin
        state_d    = ST_HUNT;
        byte_cnt_d = 4'd0;
      end
    endcase

    if (tx_accept) begin
      tx_buf_d  = tx_data;
      tx_busy_d = 1'b1;
    end

    // Response shifter: a byte loaded at byte completion must survive the trailing SCK fall.
    if (cs_fall) begin
      tx_byte_d = pick_byte(tx_buf_q, byte_cnt_q);
      fresh_d   = 1'b0;
    end else if (byte_done) begin
      tx_idx    = byte_cnt_d;
      tx_byte_d = pick_byte(tx_buf_q, tx_idx);
      fresh_d   = 1'b1;
    end else if (sck_fall & cs_low) begin
      if (fresh_q) fresh_d = 1'b0;
      else         tx_byte_d = {tx_byte_q[6:0], 1'b0};
    end
    if ((state_q == ST_DONE) || to_hit || (tx_accept && (state_q == ST_HUNT) && (bit_cnt_q == 3'd0)))
      tx_byte_d = tx_buf_d[95:88];

    miso_d = cs_low & tx_busy_d & tx_byte_d[7];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 7'd0;
      state_q     <= ST_HUNT;
      byte_cnt_q  <= 4'd0;
      rx_buf_q    <= 96'd0;
      pkt_raw_q   <= 96'd0;
      pkt_valid_q <= 1'b0;
      sync_err_q  <= 16'd0;
      tx_buf_q    <= 96'd0;
      tx_busy_q   <= 1'b0;
      tx_byte_q   <= 8'd0;
      fresh_q     <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_buf_q    <= rx_buf_d;
      pkt_raw_q   <= pkt_raw_d;
      pkt_valid_q <= pkt_valid_d;
      sync_err_q  <= sync_err_d;
      tx_buf_q    <= tx_buf_d;
      tx_busy_q   <= tx_busy_d;
      tx_byte_q   <= tx_byte_d;
      fresh_q     <= fresh_d;
      miso_q      <= miso_d;
    end
  end

`ifdef SPI_PACKET_SLAVE_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  logic [31:0] idle_q, idle_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  assign to_hit = (state_q == ST_RECV) && (idle_q >= TO_LIM);

  always_comb begin
    idle_d   = idle_q + 32'd1;
    to_cnt_d = to_cnt_q;
    if ((state_q != ST_RECV) || bit_done) idle_d = 32'd0;
    if (to_hit) to_cnt_d = sat_inc(to_cnt_q);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      idle_q   <= 32'd0;
      to_cnt_q <= 16'd0;
    end else begin
      idle_q   <= idle_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_cnt = to_cnt_q;
`else
  localparam logic [15:0] TO_ZERO = (TIMEOUT_CYCLES > 0) ? 16'h0 : 16'h0;

  assign to_hit      = 1'b0;
  assign timeout_cnt = TO_ZERO;
`endif

  assign spi_miso     = miso_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_raw      = pkt_raw_q;
  assign pkt_type     = pkt_raw_q[79:72];
  assign pkt_rw       = pkt_raw_q[64];
  assign pkt_index    = pkt_raw_q[63:48];
  assign pkt_module   = pkt_raw_q[47:40];
  assign pkt_reg      = pkt_raw_q[39:32];
  assign pkt_value    = pkt_raw_q[31:0];
  assign tx_busy      = tx_busy_q;
  assign sync_err_cnt = sync_err_q;

endmodule

// File: tb/tb_spi_packet_slave.sv
// Directed bench for spi_packet_slave: mode-0 SPI master model driving packets, checking strobes, fields and MISO.
module tb_spi_packet_slave;

  localparam int HALF   = 8;
  localparam int TO_CYC = 300;

  localparam logic [95:0] P1 = 96'h5A_00_01_01_0006_01_02_DEADBEEF;
  localparam logic [95:0] P2 = 96'h5A_00_01_00_000E_00_00_00000000;
  localparam logic [95:0] PA = 96'h5A_00_01_00_0000_00_00_00000000;
  localparam logic [95:0] PB = 96'h5A_00_01_00_0001_00_00_00000000;
  localparam logic [95:0] R1 = 96'h5A_00_02_00_000E_00_00_12345678;
  localparam logic [95:0] R2 = 96'hFF_FF_FF_FF_FFFF_FF_FF_FFFFFFFF;

  logic        clk = 1'b0;
  logic        rstb;
  logic        spi_sck, spi_n_cs, spi_mosi, spi_miso;
  logic        pkt_valid, pkt_rw, tx_load, tx_busy;
  logic [95:0] pkt_raw, tx_data;
  logic [7:0]  pkt_type, pkt_module, pkt_reg;
  logic [15:0] pkt_index, sync_err_cnt, timeout_cnt;
  logic [31:0] pkt_value;

  int          tests = 0;
  int          fails = 0;
  int          vld_cnt = 0;
  int          base;
  logic [15:0] last_idx = 16'h0;
  logic [15:0] prev_idx = 16'h0;
  logic        lat_trace [HALF];
  logic [95:0] mi;

  always #5 clk = ~clk;

  spi_packet_slave #(
    .SYNC_STAGES(2),
    .MAGIC(8'h5A),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rstb(rstb),
    .spi_sck(spi_sck), .spi_n_cs(spi_n_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .pkt_valid(pkt_valid), .pkt_raw(pkt_raw), .pkt_type(pkt_type), .pkt_rw(pkt_rw),
    .pkt_index(pkt_index), .pkt_module(pkt_module), .pkt_reg(pkt_reg), .pkt_value(pkt_value),
    .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy),
    .sync_err_cnt(sync_err_cnt), .timeout_cnt(timeout_cnt)
  );

  always @(negedge clk) begin
    if (pkt_valid === 1'b1) begin
      vld_cnt  <= vld_cnt + 1;
      prev_idx <= last_idx;
      last_idx <= pkt_index;
    end
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tb, output logic [7:0] rb);
    rb = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tb[i];
      wait_clk(HALF);
      rb[i] = spi_miso;
      spi_sck = 1'b1;
      for (int j = 0; j < HALF; j++) begin
        @(negedge clk);
        lat_trace[j] = pkt_valid;
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic send(input logic [95:0] p, input int nbytes, input bit tog, input bit hold,
                      output logic [95:0] mo);
    logic [7:0] rb;
    mo = 96'h0;
    for (int k = 0; k < nbytes; k++) begin
      if (spi_n_cs) begin
        spi_n_cs = 1'b0;
        wait_clk(2);
      end
      xfer(p[95-8*k -: 8], rb);
      mo = {mo[87:0], rb};
      if (tog && (k != nbytes - 1)) begin
        wait_clk(HALF);
        spi_n_cs = 1'b1;
        wait_clk(6);
      end
    end
    if (!hold) begin
      wait_clk(HALF);
      spi_n_cs = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic load_tx(input logic [95:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    wait_clk(2);
  endtask

  initial begin
    rstb = 1'b0; spi_sck = 1'b0; spi_n_cs = 1'b1; spi_mosi = 1'b0;
    tx_data = 96'h0; tx_load = 1'b0;
    wait_clk(4);
    chk("rst_pkt_valid", 96'(pkt_valid), 96'h0);
    chk("rst_pkt_raw", pkt_raw, 96'h0);
    chk("rst_miso", 96'(spi_miso), 96'h0);
    chk("rst_tx_busy", 96'(tx_busy), 96'h0);
    chk("rst_sync_err", 96'(sync_err_cnt), 96'h0);
    chk("rst_timeout", 96'(timeout_cnt), 96'h0);
    rstb = 1'b1;
    wait_clk(4);

    // Single write packet, no response loaded
    base = vld_cnt;
    send(P1, 12, 1'b0, 1'b0, mi);
    chk("t1_strobes", 96'(vld_cnt - base), 96'd1);
    chk("t1_lat_before", 96'(lat_trace[2]), 96'h0);
    chk("t1_lat_edge", 96'(lat_trace[3]), 96'h1);
    chk("t1_lat_width", 96'(lat_trace[4]), 96'h0);
    chk("t1_raw", pkt_raw, P1);
    chk("t1_type", 96'(pkt_type), 96'h01);
    chk("t1_rw", 96'(pkt_rw), 96'h1);
    chk("t1_index", 96'(pkt_index), 96'h0006);
    chk("t1_module", 96'(pkt_module), 96'h01);
    chk("t1_reg", 96'(pkt_reg), 96'h02);
    chk("t1_value", 96'(pkt_value), 96'hDEADBEEF);
    chk("t1_sync_err", 96'(sync_err_cnt), 96'h0);
    chk("t1_miso_idle", mi, 96'h0);

    // Garbage byte before the magic
    base = vld_cnt;
    send({8'h33, 88'h0}, 1, 1'b0, 1'b0, mi);
    chk("t2_sync_err_garbage", 96'(sync_err_cnt), 96'h1);
    send(P2, 12, 1'b0, 1'b0, mi);
    chk("t2_strobes", 96'(vld_cnt - base), 96'd1);
    chk("t2_rw", 96'(pkt_rw), 96'h0);
    chk("t2_index", 96'(pkt_index), 96'h000E);
    chk("t2_sync_err", 96'(sync_err_cnt), 96'h1);

    // Response shift-out; a second load while busy is ignored
    load_tx(R1);
    chk("t3_busy_set", 96'(tx_busy), 96'h1);
    load_tx(R2);
    send(P1, 12, 1'b0, 1'b0, mi);
    chk("t3_miso", mi, R1);
    chk("t3_busy_clear", 96'(tx_busy), 96'h0);
    send(P1, 12, 1'b0, 1'b0, mi);
    chk("t3_miso_after", mi, 96'h0);

    // Asynchronous reset mid-packet
    load_tx(R1);
    base = vld_cnt;
    send(P1, 5, 1'b0, 1'b1, mi);
    rstb = 1'b0;
    wait_clk(2);
    chk("t4_rst_valid", 96'(pkt_valid), 96'h0);
    chk("t4_rst_raw", pkt_raw, 96'h0);
    chk("t4_rst_type", 96'(pkt_type), 96'h0);
    chk("t4_rst_busy", 96'(tx_busy), 96'h0);
    chk("t4_rst_sync_err", 96'(sync_err_cnt), 96'h0);
    chk("t4_rst_miso", 96'(spi_miso), 96'h0);
    spi_n_cs = 1'b1;
    wait_clk(2);
    rstb = 1'b1;
    wait_clk(4);
    send(P2, 12, 1'b0, 1'b0, mi);
    chk("t4_strobes", 96'(vld_cnt - base), 96'd1);
    chk("t4_raw", pkt_raw, P2);

    // Back-to-back packets with n_cs toggled around every byte
    base = vld_cnt;
    send(PA, 12, 1'b1, 1'b0, mi);
    send(PB, 12, 1'b1, 1'b0, mi);
    chk("t6_strobes", 96'(vld_cnt - base), 96'd2);
    chk("t6_first_index", 96'(prev_idx), 96'h0000);
    chk("t6_second_index", 96'(last_idx), 96'h0001);

    // Two packets with n_cs held low across the boundary
    base = vld_cnt;
    send(P1, 12, 1'b0, 1'b1, mi);
    send(P2, 12, 1'b0, 1'b0, mi);
    chk("t7_strobes", 96'(vld_cnt - base), 96'd2);
    chk("t7_first_index", 96'(prev_idx), 96'h0006);
    chk("t7_second_index", 96'(last_idx), 96'h000E);
    chk("t7_sync_err", 96'(sync_err_cnt), 96'h0);

`ifdef SPI_PACKET_SLAVE_TIMEOUT_EN
    // Stalled packet is dropped by the idle timeout
    base = vld_cnt;
    send(P1, 6, 1'b0, 1'b0, mi);
    wait_clk(TO_CYC + 10);
    chk("t5_timeout_cnt", 96'(timeout_cnt), 96'h1);
    send(P2, 12, 1'b0, 1'b0, mi);
    chk("t5_strobes", 96'(vld_cnt - base), 96'd1);
    chk("t5_raw", pkt_raw, P2);
    chk("t5_timeout_after", 96'(timeout_cnt), 96'h1);
`else
    chk("t5_timeout_tied", 96'(timeout_cnt), 96'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_packet_slave.md
Name: spi_packet_slave

Overview:
- MCU-facing SPI slave that receives the 12-byte (96-bit) command packets issued by the MCU SPI master.
- Resynchronises packet framing on the 0x5A magic byte, decodes the fields and presents them to the central command logic with a one-cycle strobe.
- Shifts a previously loaded 96-bit response packet out on MISO during the next packet.
- All SPI pins are sampled and oversampled in the fabric clock domain; no SCK-clocked flops.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for sck/n_cs/mosi (valid range 2..3).
- MAGIC, 8'h5A, required first byte of every packet.
- TIMEOUT_CYCLES, 20000, idle clk cycles mid-packet before framing is dropped (used only with the optional feature).

Ports:
- clk  in  1  fabric clock; must be at least 4x SCK frequency.
- rstb  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_n_cs  in  1  chip select, active low.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data, MSB first.
- pkt_valid  out  1  one-clk strobe: a complete, magic-aligned packet has been received.
- pkt_raw  out  96  full received packet; byte 0 is in bits [95:88].
- pkt_type  out  8  packet byte 2.
- pkt_rw  out  1  bit 0 of packet byte 3 (1 = write).
- pkt_index  out  16  packet bytes 4-5.
- pkt_module  out  8  packet byte 6.
- pkt_reg  out  8  packet byte 7.
- pkt_value  out  32  packet bytes 8-11.
- tx_data  in  96  response packet to send.
- tx_load  in  1  one-clk request to latch tx_data.
- tx_busy  out  1  a response is latched and has not been fully shifted out.
- sync_err_cnt  out  16  count of non-magic bytes discarded at byte 0; saturating.
- timeout_cnt  out  16  count of packets dropped by timeout; saturating; reads 0 when the optional feature is compiled out.

Behaviour:
- Reset values: spi_miso=0, pkt_valid=0, all pkt_* fields=0, tx_busy=0, both counters=0, byte counter=0, FSM=HUNT.
- Input synchronisation: SYNC_STAGES flops on each SPI pin, then one edge-detect register.
- A bit is received on a synchronised SCK rising edge while n_cs is low.
  - SCK edges while n_cs is high are ignored.
  - n_cs going high mid-byte discards the partial bit count. It does not reset the byte counter, because the master may toggle n_cs per byte.
- FSM states:
  - HUNT: on each completed byte, if byte == MAGIC, store it as byte 0 and go to RECV with byte counter = 1. Otherwise increment sync_err_cnt and stay in HUNT.
  - RECV: store each completed byte at the byte counter position. After byte 11 completes, go to DONE.
  - DONE: for exactly one clk, assert pkt_valid and update pkt_raw and all fields together; then return to HUNT with byte counter = 0.
- Field registers hold their value until the next pkt_valid.
- Latency: pkt_valid rises exactly SYNC_STAGES+2 clk after the raw SCK rising edge of bit 0 of byte 11.
- Back-to-back packets are supported with zero gap; a magic byte arriving in the cycle after DONE is accepted.
- MISO, shift side:
  - Falling n_cs, or completion of the previous byte, presents the MSB of response byte k, where k is the current receive byte counter.
  - Each synchronised SCK falling edge shifts to the next bit.
  - The response is aligned with receive byte positions; it is only shifted while in RECV or while HUNT has just accepted the magic byte.
- MISO, what is driven:
  - While n_cs is high, spi_miso=0.
  - With tx_busy=0, spi_miso=0 during every byte.
- tx_load:
  - Accepted only when tx_busy=0 and FSM=HUNT; otherwise ignored, with no queueing.
  - Acceptance latches tx_data and sets tx_busy.
  - tx_busy clears in the DONE cycle of the packet during which response byte 11 was shifted.
- Simultaneous tx_load and DONE: the load is accepted and the new response goes out with the next packet.
- Counters saturate at 16'hFFFF.
- Asynchronous reset mid-packet: all state clears immediately; no pkt_valid is generated for the partial packet.

Optional Feature:
- Macro SPI_PACKET_SLAVE_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter runs while FSM=RECV.
  - It is cleared on every completed bit.
  - On reaching TIMEOUT_CYCLES: FSM returns to HUNT, byte counter = 0, timeout_cnt increments, and tx_busy is preserved (the response is re-sent from byte 0).
- Undefined:
  - No counter logic is synthesised and timeout_cnt is tied to 0.
  - Framing is recovered only through magic resync.

Test Plan:
1. Send 96'h5A_00_01_01_0006_01_02_DEADBEEF → single pkt_valid; pkt_type=01, pkt_rw=1, pkt_index=0006, pkt_module=01, pkt_reg=02, pkt_value=DEADBEEF; sync_err_cnt=0.
2. Send byte 8'h33 then 96'h5A_00_01_00_000E_00_00_00000000 → sync_err_cnt=1, one pkt_valid with pkt_rw=0 and pkt_index=000E.
3. tx_load with 96'h5A_00_02_00_000E_00_00_12345678, then send any valid packet → MISO bytes read 5A,00,02,00,00,0E,00,00,12,34,56,78; tx_busy=0 after DONE; the next packet reads all 00.
4. Assert rstb low after 5 bytes, release, then send a full packet → no strobe for the partial packet, all outputs 0 during reset, exactly one pkt_valid for the full packet.
5. With SPI_PACKET_SLAVE_TIMEOUT_EN: send 6 bytes, idle TIMEOUT_CYCLES+10 clk, then a full packet → timeout_cnt=1, one pkt_valid with correct fields.
6. Two packets back to back with per-byte n_cs toggling → two pkt_valid strobes, each carrying its own pkt_index (0000 then 0001).
